midi_msg_parser: RTL

MIDI_MSG_PARSER -- requirements
Module: midi_msg_parser

---
 rtl/midi_pkg.sv | 47 ++++
 rtl/midi_msg_fifo.sv | 98 +++++++++
 rtl/midi_msg_parser.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/midi_pkg.sv
// Shared MIDI definitions: parser state encoding, status-byte class
// constants and the data-length lookup used by the message parser.
package midi_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT_D1 = 2'd1,
        ST_WAIT_D2 = 2'd2,
        ST_SYSEX   = 2'd3
    } midi_state_e;

    localparam logic [7:0] MIDI_STATUS_MIN = 8'h80;  // lowest status byte
    localparam logic [7:0] MIDI_SYS_MIN    = 8'hF0;  // first system byte (SysEx start)
    localparam logic [7:0] MIDI_EOX        = 8'hF7;  // end of SysEx
    localparam logic [7:0] MIDI_RT_MIN     = 8'hF8;  // first realtime byte
    localparam logic [7:0] MIDI_TUNE_REQ   = 8'hF6;  // tune request, no data

    // Number of data bytes that follow a status byte (0 for anything
    // that never carries data).
    function automatic logic [1:0] midi_data_len(input logic [7:0] status);
        logic [1:0] len;
        case (status[7:4])
            4'h8, 4'h9, 4'hA, 4'hB, 4'hE: len = 2'd2;
            4'hC, 4'hD:                   len = 2'd1;
            4'hF: begin
                case (status)
                    8'hF1, 8'hF3: len = 2'd1;
                    8'hF2:        len = 2'd2;
                    default:      len = 2'd0;
                endcase
            end
            default: len = 2'd0;
        endcase
        return len;
    endfunction

    // Undefined system bytes: dropped and treated as a hard resync.
    function automatic logic midi_is_undefined(input logic [7:0] b);
        return (b == 8'hF4) || (b == 8'hF5) || (b == 8'hF9) || (b == 8'hFD);
    endfunction

    // Defined realtime bytes; they interleave with anything.
    function automatic logic midi_is_realtime(input logic [7:0] b);
        return (b >= MIDI_RT_MIN) && !midi_is_undefined(b);
    endfunction

endpackage

// File: rtl/midi_msg_fifo.sv
// Synchronous show-ahead FIFO for parsed MIDI messages. Pointers carry one
// extra wrap bit so full and empty are distinguishable without a counter.
// A push into a full FIFO is dropped and latches a sticky overflow flag,
// unless a pop happens in the same cycle.
module midi_msg_fifo
    import midi_pkg::*;
#(
    parameter int W     = 26,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push_i,
    input  logic [W-1:0] push_data_i,
    input  logic         pop_i,
    output logic         valid_o,
    output logic [W-1:0] head_o,
    output logic         overflow_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [W-1:0]  mem_q [DEPTH];
    logic [PW-1:0] wr_q;
    logic [PW-1:0] wr_d;
    logic [PW-1:0] rd_q;
    logic [PW-1:0] rd_d;
    logic          overflow_q;
    logic          overflow_d;

    logic          empty_s;
    logic          full_s;
    logic          pop_ok_s;
    logic          push_ok_s;
    logic [AW-1:0] wr_idx_s;
    logic [AW-1:0] rd_idx_s;

    assign wr_idx_s  = wr_q[AW-1:0];
    assign rd_idx_s  = rd_q[AW-1:0];
    assign empty_s   = (wr_q == rd_q);
    assign full_s    = (wr_q[AW] != rd_q[AW]) && (wr_idx_s == rd_idx_s);
    assign pop_ok_s  = pop_i && !empty_s;
    assign push_ok_s = push_i && (!full_s || pop_ok_s);

    // Pointer advance and sticky overflow detection.
    always_comb begin
        wr_d       = wr_q;
        rd_d       = rd_q;
        overflow_d = overflow_q;
        if (push_ok_s) begin
            wr_d = wr_q + {{AW{1'b0}}, 1'b1};
        end else begin
            wr_d = wr_q;
        end
        if (pop_ok_s) begin
            rd_d = rd_q + {{AW{1'b0}}, 1'b1};
        end else begin
            rd_d = rd_q;
        end
        if (push_i && !push_ok_s) begin
            overflow_d = 1'b1;
        end else begin
            overflow_d = overflow_q;
        end
    end

    // Pointer and overflow state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q       <= {PW{1'b0}};
            rd_q       <= {PW{1'b0}};
            overflow_q <= 1'b0;
        end else begin
            wr_q       <= wr_d;
            rd_q       <= rd_d;
            overflow_q <= overflow_d;
        end
    end

    // Message storage; cleared on reset so the head never shows stale data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= {W{1'b0}};
            end
        end else if (push_ok_s) begin
            mem_q[wr_idx_s] <= push_data_i;
        end else begin
            mem_q[wr_idx_s] <= mem_q[wr_idx_s];
        end
    end

    assign valid_o    = !empty_s;
    assign head_o     = empty_s ? {W{1'b0}} : mem_q[rd_idx_s];
    assign overflow_o = overflow_q;

endmodule

// File: rtl/midi_msg_parser.sv
// MIDI byte-stream parser: turns received bytes into complete channel and
// system-common messages (with running status), passes realtime bytes
// through as zero-data messages, discards SysEx payloads and queues the
// results in a small show-ahead FIFO.
module midi_msg_parser
    import midi_pkg::*;
#(
    parameter int BYTE_W     = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    input  logic [BYTE_W-1:0] rx_byte,
    input  logic              rx_strobe,
    output logic              msg_valid,
    input  logic              msg_ready,
    output logic [BYTE_W-1:0] msg_status,
    output logic [BYTE_W-1:0] msg_data1,
    output logic [BYTE_W-1:0] msg_data2,
    output logic [1:0]        msg_len,
    output logic              overflow
);

    localparam int MSG_W = 3 * BYTE_W + 2;
    localparam logic [BYTE_W-1:0] ZERO_B = {BYTE_W{1'b0}};

    // Strobe edge detection and byte capture
    logic              strobe_q;
    logic              event_q;
    logic [BYTE_W-1:0] byte_q;

    // Parser state
    midi_state_e       state_q;
    midi_state_e       state_d;
    logic [BYTE_W-1:0] rs_q;
    logic [BYTE_W-1:0] rs_d;
    logic              rs_valid_q;
    logic              rs_valid_d;
    logic [BYTE_W-1:0] stat_q;
    logic [BYTE_W-1:0] stat_d;
    logic [BYTE_W-1:0] d1_q;
    logic [BYTE_W-1:0] d1_d;

    logic              push_s;
    logic [MSG_W-1:0]  push_word_s;
    logic              pop_s;
    logic              fifo_valid_s;
    logic [MSG_W-1:0]  head_s;
    logic [7:0]        b8_s;
    logic              is_status_s;

    // Classification only looks at the MIDI-defined low eight bits.
    assign b8_s        = byte_q[7:0];
    assign is_status_s = (b8_s >= MIDI_STATUS_MIN);

    function automatic logic [MSG_W-1:0] pack_msg(
        input logic [BYTE_W-1:0] st,
        input logic [BYTE_W-1:0] d1,
        input logic [BYTE_W-1:0] d2,
        input logic [1:0]        len
    );
        return {st, d1, d2, len};
    endfunction

    // Rising-edge detect on the strobe; the byte is captured with the edge
    // and processed on the following cycle.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            strobe_q <= 1'b0;
            event_q  <= 1'b0;
            byte_q   <= {BYTE_W{1'b0}};
        end else begin
            strobe_q <= rx_strobe;
            event_q  <= rx_strobe && !strobe_q;
            if (rx_strobe && !strobe_q) begin
                byte_q <= rx_byte;
            end else begin
                byte_q <= byte_q;
            end
        end
    end

    // Parser next-state, running-status tracking and message push decode.
    always_comb begin
        state_d     = state_q;
        rs_d        = rs_q;
        rs_valid_d  = rs_valid_q;
        stat_d      = stat_q;
        d1_d        = d1_q;
        push_s      = 1'b0;
        push_word_s = {MSG_W{1'b0}};
        if (event_q) begin
            if (midi_is_undefined(b8_s)) begin
                state_d    = ST_IDLE;
                rs_valid_d = 1'b0;
            end else if (midi_is_realtime(b8_s)) begin
                // Realtime leaves every piece of parser context untouched.
                push_s      = 1'b1;
                push_word_s = pack_msg(byte_q, ZERO_B, ZERO_B, 2'd0);
            end else if (is_status_s) begin
                // Any status byte abandons a partial message or a SysEx.
                if (b8_s < MIDI_SYS_MIN) begin
                    rs_d       = byte_q;
                    rs_valid_d = 1'b1;
                    stat_d     = byte_q;
                    state_d    = ST_WAIT_D1;
                end else begin
                    case (b8_s)
                        MIDI_SYS_MIN: begin
                            rs_valid_d = 1'b0;
                            state_d    = ST_SYSEX;
                        end
                        8'hF1, 8'hF2, 8'hF3: begin
                            rs_valid_d = 1'b0;
                            stat_d     = byte_q;
                            state_d    = ST_WAIT_D1;
                        end
                        MIDI_TUNE_REQ: begin
                            rs_valid_d  = 1'b0;
                            push_s      = 1'b1;
                            push_word_s = pack_msg(byte_q, ZERO_B, ZERO_B, 2'd0);
                            state_d     = ST_IDLE;
                        end
                        MIDI_EOX: begin
                            state_d = ST_IDLE;
                        end
                        default: begin
                            state_d = ST_IDLE;
                        end
                    endcase
                end
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (rs_valid_q) begin
                            stat_d = rs_q;
                            d1_d   = byte_q;
                            if (midi_data_len(rs_q[7:0]) == 2'd1) begin
                                push_s      = 1'b1;
                                push_word_s = pack_msg(rs_q, byte_q, ZERO_B, 2'd1);
                                state_d     = ST_IDLE;
                            end else begin
                                state_d = ST_WAIT_D2;
                            end
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end
                    ST_WAIT_D1: begin
                        d1_d = byte_q;
                        if (midi_data_len(stat_q[7:0]) == 2'd1) begin
                            push_s      = 1'b1;
                            push_word_s = pack_msg(stat_q, byte_q, ZERO_B, 2'd1);
                            state_d     = ST_IDLE;
                        end else begin
                            state_d = ST_WAIT_D2;
                        end
                    end
                    ST_WAIT_D2: begin
                        push_s      = 1'b1;
                        push_word_s = pack_msg(stat_q, d1_q, byte_q, 2'd2);
                        state_d     = ST_IDLE;
                    end
                    ST_SYSEX: begin
                        state_d = ST_SYSEX;
                    end
                    default: begin
                        state_d = ST_IDLE;
                    end
                endcase
            end
        end else begin
            state_d = state_q;
        end
    end

    // Parser state registers.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q    <= ST_IDLE;
            rs_q       <= {BYTE_W{1'b0}};
            rs_valid_q <= 1'b0;
            stat_q     <= {BYTE_W{1'b0}};
            d1_q       <= {BYTE_W{1'b0}};
        end else begin
            state_q    <= state_d;
            rs_q       <= rs_d;
            rs_valid_q <= rs_valid_d;
            stat_q     <= stat_d;
            d1_q       <= d1_d;
        end
    end

    assign pop_s = fifo_valid_s && msg_ready;

    midi_msg_fifo #(
        .W     (MSG_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk         (sys_clk),
        .rst_n       (sys_rst_n),
        .push_i      (push_s),
        .push_data_i (push_word_s),
        .pop_i       (pop_s),
        .valid_o     (fifo_valid_s),
        .head_o      (head_s),
        .overflow_o  (overflow)
    );

    assign msg_valid = fifo_valid_s;
    assign {msg_status, msg_data1, msg_data2, msg_len} = head_s;

endmodule
